fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of the team's 8-deep gray-pointer async FIFO among NREQ requesters in the FIFO write clock domain. Each requester presents beats on a valid/ready handshake, with an end-of-packet marker. The granted requester keeps the FIFO write port until it sends its last beat or reaches MAX_BURST beats, so packets from different requesters never interleave below that burst size.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, data width; matches the FIFO data width
MAX_BURST, 4, maximum beats per grant before forced rotation (power of 2, >=2)
GW, 2, width of gnt_id; equals clog2(NREQ)

Ports:
clka  in  1  clock; the FIFO write clock
rsta  in  1  asynchronous reset, active-high
req_vld  in  NREQ  per-requester beat valid
req_last  in  NREQ  per-requester end-of-packet; qualified by req_vld
req_dat  in  NREQ*DSIZE  per-requester data; requester i uses bits [i*DSIZE +: DSIZE]
req_rdy  out  NREQ  per-requester beat accepted; at most one bit set
fifo_wreq  out  1  write strobe to the FIFO wreqa
fifo_wdata  out  DSIZE  write data to the FIFO data input
fifo_full  in  1  FIFO fulla
gnt_id  out  GW  index of the current or last granted requester
busy  out  1  high while a grant is held

Behaviour:
- Clock and reset: one clock (clka). Reset is asynchronous and active-high (rsta); asserting it forces reset state immediately, without waiting for a clock edge.
- Reset values: state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0. Outputs: busy=0, fifo_wreq=0, req_rdy=0, fifo_wdata=0.
- State machine: two states, IDLE and GRANT.
- IDLE, no req_vld bit set: stay in IDLE.
- IDLE, any req_vld bit set: select the first set bit found by searching indices rr_ptr, rr_ptr+1, ... modulo NREQ. Register the result into gnt_id, clear beat_cnt and move to GRANT. Arbitration takes 1 cycle; no transfer happens in IDLE.
- GRANT, transfer condition: xfer = req_vld[gnt_id] & ~fifo_full. This is combinational.
- GRANT, outputs: fifo_wreq = xfer. req_rdy[gnt_id] = xfer; all other req_rdy bits are 0. fifo_wdata = req_dat slice of gnt_id.
- Outside GRANT: fifo_wdata=0, fifo_wreq=0, req_rdy=0.
- GRANT, counting: beat_cnt increments on each xfer.
- GRANT, release: on an xfer with req_last[gnt_id]=1, or an xfer with beat_cnt==MAX_BURST-1. At release: state goes to IDLE, rr_ptr <= (gnt_id+1) mod NREQ, beat_cnt <= 0. This leaves exactly one idle bubble between grants.
- Held grant: if req_vld[gnt_id] drops mid-packet, the grant stays held indefinitely. Other requesters wait; no timeout.
- fifo_full: blocks xfer, so fifo_wreq and req_rdy stay 0. beat_cnt holds. State is unchanged.
- Overflow guarantee: fifo_wreq is never asserted while fifo_full=1. The FIFO's conservative full flag makes the combinational gating sufficient.
- busy = (state==GRANT). gnt_id holds its value in IDLE until the next arbitration.
- Requester changes: a req_vld change on a non-granted requester has no effect until the next IDLE cycle.
- Same-cycle last and burst limit: req_last=1 together with beat_cnt==MAX_BURST-1 gives a single release, with no double rotate.
- Wrap-around: beat_cnt is clog2(MAX_BURST) bits wide and never wraps, because release happens at MAX_BURST-1. rr_ptr wraps from NREQ-1 to 0.
- Reset mid-burst: fifo_wreq and req_rdy drop asynchronously. A partially written packet is not recovered; the FIFO is reset by the system alongside.

Test Plan:
1. Reset: hold rsta=1 with random req_vld. Required: fifo_wreq=0, req_rdy=0, busy=0, gnt_id=0, fifo_wdata=0 throughout.
2. Single requester: requester 1 sends 0x11, 0x12, 0x13, with req_last on 0x13; fifo_full=0. Required: one IDLE cycle, then 3 consecutive fifo_wreq cycles with data 0x11/0x12/0x13 and gnt_id=1, then busy=0 and next search starts at rr_ptr=2.
3. Fairness: all four requesters continuously valid, req_last never set. Required: grant order 0, 1, 2, 3, 0, each exactly 4 beats, with one bubble cycle between grants.
4. Backpressure: fifo_full=1 for 3 cycles after the 2nd beat of a grant. Required: fifo_wreq=0 and req_rdy=0 for those 3 cycles. The 3rd beat is written on the first cycle with fifo_full=0, and the grant still releases after 4 total beats.
5. Held grant: requester 2 is granted, sends 1 beat, then drops req_vld for 5 cycles while requester 3 is valid. Required: gnt_id stays 2, busy=1, no writes. Writes resume when requester 2 reasserts.
6. Reset mid-operation: assert rsta between edges during the 2nd beat of a burst. Required: fifo_wreq and req_rdy fall before the next edge. After release, the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// A grant is held until end-of-packet or MAX_BURST beats, then the pointer rotates.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int GW        = 2
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_dat,
  output logic [NREQ-1:0]       req_rdy,
  output logic                  fifo_wreq,
  output logic [DSIZE-1:0]      fifo_wdata,
  input  logic                  fifo_full,
  output logic [GW-1:0]         gnt_id,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]   gnt_reg, gnt_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [GW-1:0]   pick;
  logic [GW:0]     sum;
  logic            xfer;
  logic            release_now;
  logic [DSIZE-1:0] dat_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign dat_arr[gi] = req_dat[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid index after rr_ptr wins.
  always_comb begin
    pick = rr_ptr_reg;
    sum  = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_reg} + (GW+1)'(k);
      if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
      if (req_vld[sum[GW-1:0]]) pick = sum[GW-1:0];
    end
  end

  assign busy        = (state_reg == GRANT);
  assign xfer        = busy & req_vld[gnt_reg] & ~fifo_full;
  assign release_now = xfer & (req_last[gnt_reg] | (beat_cnt_reg == CW'(MAX_BURST-1)));
  assign fifo_wreq   = xfer;
  assign gnt_id      = gnt_reg;

  always_comb begin
    req_rdy = '0;
    if (xfer) req_rdy[gnt_reg] = 1'b1;
  end

  always_comb begin
    fifo_wdata = '0;
    if (busy) fifo_wdata = dat_arr[gnt_reg];
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_next      = gnt_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vld) begin
          gnt_next      = pick;
          beat_cnt_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_next    = IDLE;
          beat_cnt_next = '0;
          rr_ptr_next   = (gnt_reg == GW'(NREQ-1)) ? '0 : gnt_reg + GW'(1);
        end else if (xfer) begin
          beat_cnt_next = beat_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_reg      <= gnt_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single packet, fairness, backpressure,
// held grant and asynchronous reset in the middle of a burst.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4, DSIZE = 8, MAX_BURST = 4, GW = 2;

  logic                  clka = 1'b0;
  logic                  rsta;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_dat;
  logic [NREQ-1:0]       req_rdy;
  logic                  fifo_wreq;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_full;
  logic [GW-1:0]         gnt_id;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .GW(GW)) dut (
    .clka(clka), .rsta(rsta), .req_vld(req_vld), .req_last(req_last), .req_dat(req_dat),
    .req_rdy(req_rdy), .fifo_wreq(fifo_wreq), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clka = ~clka;

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output against one expected set.
  task automatic chk_all(input string tag, input logic b, input logic w,
                         input logic [3:0] rdy, input logic [1:0] g, input logic [7:0] d);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".wreq"}, 32'(fifo_wreq), 32'(w));
    chk({tag, ".rdy"},  32'(req_rdy), 32'(rdy));
    chk({tag, ".gnt"},  32'(gnt_id), 32'(g));
    chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(d));
  endtask

  task automatic cyc;
    @(posedge clka);
    #1;
  endtask

  initial begin
    rsta = 1'b1; req_vld = '0; req_last = '0; req_dat = '0; fifo_full = 1'b0;

    // 1: reset held with random requests
    for (int i = 0; i < 4; i++) begin
      req_vld = 4'($urandom_range(0, 15));
      #1 chk_all("reset", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
      cyc;
    end
    req_vld = '0;
    rsta = 1'b0;

    // 2: single packet from requester 1
    req_vld = 4'b0010; req_dat[8 +: 8] = 8'h11;
    #1 chk_all("single.idle", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    cyc; chk_all("single.b0", 1'b1, 1'b1, 4'b0010, 2'd1, 8'h11);
    cyc; req_dat[8 +: 8] = 8'h12;
    #1 chk_all("single.b1", 1'b1, 1'b1, 4'b0010, 2'd1, 8'h12);
    cyc; req_dat[8 +: 8] = 8'h13; req_last = 4'b0010;
    #1 chk_all("single.b2", 1'b1, 1'b1, 4'b0010, 2'd1, 8'h13);
    cyc; req_vld = 4'b0101; req_last = 4'b0100; req_dat[16 +: 8] = 8'h55;
    #1 chk_all("single.rel", 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00);
    cyc; chk_all("rrptr2", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h55);
    req_vld = 4'b0100;
    cyc; req_vld = '0; req_last = '0;
    #1 chk_all("rrptr2.rel", 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00);

    // 3: fairness after reset, all requesters continuously valid
    rsta = 1'b1; #1 rsta = 1'b0;
    req_dat = 32'hA3A2A1A0; req_vld = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1 chk("fair.bubble", 32'(fifo_wreq), 32'd0);
      cyc;
      for (int b = 0; b < MAX_BURST; b++) begin
        chk_all("fair.beat", 1'b1, 1'b1, 4'(1 << (g % 4)), 2'(g % 4), 8'hA0 + 8'(g % 4));
        cyc;
      end
    end

    // 4: backpressure on requester 1 after its 2nd beat
    chk_all("bp.idle", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    cyc; chk_all("bp.b0", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
    cyc; chk_all("bp.b1", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
    cyc; fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_all("bp.full", 1'b1, 1'b0, 4'b0000, 2'd1, 8'hA1);
      cyc;
    end
    fifo_full = 1'b0;
    #1 chk_all("bp.b2", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
    cyc; chk_all("bp.b3", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);
    cyc; req_vld = 4'b1100;
    #1 chk_all("bp.rel", 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00);

    // 5: requester 2 holds its grant while idle, requester 3 waits
    cyc; chk_all("hold.b0", 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2);
    cyc; req_vld = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1 chk_all("hold.gap", 1'b1, 1'b0, 4'b0000, 2'd2, 8'hA2);
      cyc;
    end
    req_vld = 4'b1100;
    #1 chk_all("hold.b1", 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2);
    cyc; req_last = 4'b0100;
    #1 chk_all("hold.b2", 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2);
    cyc; req_last = '0; req_vld = 4'b1110;
    #1 chk_all("hold.rel", 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00);

    // 6: asynchronous reset during the 2nd beat of requester 3
    cyc; chk_all("rst.b0", 1'b1, 1'b1, 4'b1000, 2'd3, 8'hA3);
    cyc; chk_all("rst.b1", 1'b1, 1'b1, 4'b1000, 2'd3, 8'hA3);
    #1 rsta = 1'b1;
    #1 chk_all("rst.async", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    #1 rsta = 1'b0;
    #1 chk_all("rst.idle", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    cyc; chk_all("rst.regrant", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
